// File: rtl/clock_phase_gen.sv
// Four-phase computer clock generator with run / halt / single-step control.
// Drives the stepper's cpu_clk and step_rst; every output is registered.
module clock_phase_gen #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  input  logic             halt,
  output logic             cpu_clk,
  output logic             clk_d,
  output logic             clk_e,
  output logic             clk_s,
  output logic             step_rst,
  output logic             busy,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DMax = DW'(DIV - 1);

  typedef enum logic [1:0] {StRstHold, StIdle, StRun, StSingle} state_e;

  state_e          state_q, state_d;
  logic [1:0]      q_q, q_d;
  logic [DW-1:0]   d_q, d_d;
  logic [1:0]      hold_q, hold_d;
  logic            cycle_end;

  logic             cpu_clk_q, cpu_clk_d;
  logic             clk_d_q, clk_d_d;
  logic             clk_e_q, clk_e_d;
  logic             clk_s_q, clk_s_d;
  logic             step_rst_q, step_rst_d;
  logic             busy_q, busy_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             active_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRstHold;
      q_q          <= 2'd0;
      d_q          <= '0;
      hold_q       <= 2'd0;
      cpu_clk_q    <= 1'b0;
      clk_d_q      <= 1'b0;
      clk_e_q      <= 1'b0;
      clk_s_q      <= 1'b0;
      step_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      d_q          <= d_d;
      hold_q       <= hold_d;
      cpu_clk_q    <= cpu_clk_d;
      clk_d_q      <= clk_d_d;
      clk_e_q      <= clk_e_d;
      clk_s_q      <= clk_s_d;
      step_rst_q   <= step_rst_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    d_d       = d_q;
    hold_d    = hold_q;
    cycle_end = 1'b0;
    unique case (state_q)
      StRstHold: begin
        hold_d = hold_q + 2'd1;
        if (hold_q == 2'd3) state_d = StIdle;
      end
      StIdle: begin
        if (!halt && (run || step_req)) begin
          state_d = run ? StRun : StSingle;
          q_d     = 2'd0;
          d_d     = '0;
        end
      end
      StRun, StSingle: begin
        if (d_q == DMax) begin
          d_d = '0;
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            cycle_end = 1'b1;
            if (state_q == StSingle || !run || halt) state_d = StIdle;
          end
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge
  always_comb begin
    active_d     = (state_d == StRun) || (state_d == StSingle);
    cpu_clk_d    = active_d && !q_d[1];
    clk_d_d      = active_d && (q_d[1] ^ q_d[0]);
    clk_e_d      = cpu_clk_d || clk_d_d;
    clk_s_d      = cpu_clk_d && clk_d_d;
    step_rst_d   = (state_d == StRstHold);
    busy_d       = active_d;
    cycle_done_d = cycle_end;
    cycle_cnt_d  = cycle_cnt_q + CNT_W'(cycle_end);
  end

  assign cpu_clk    = cpu_clk_q;
  assign clk_d      = clk_d_q;
  assign clk_e      = clk_e_q;
  assign clk_s      = clk_s_q;
  assign step_rst   = step_rst_q;
  assign busy       = busy_q;
  assign cycle_done = cycle_done_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: two instances (DIV=2/CNT_W=16 and DIV=1/CNT_W=4) share stimulus
// and are compared every clk against a cycle-position reference model.
module tb_clock_phase_gen;

  localparam int MHold = 0, MIdle = 1, MRun = 2, MSingle = 3;

  typedef struct {
    int mode;
    int hold;
    int pos;   // clk index within the current computer cycle
    int cnt;
    bit done;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, run, step_req, halt;

  logic a_cpu, a_cd, a_ce, a_cs, a_sr, a_busy, a_done;
  logic [15:0] a_cnt;
  logic b_cpu, b_cd, b_ce, b_cs, b_sr, b_busy, b_done;
  logic [3:0] b_cnt;

  int total = 0;
  int bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  clock_phase_gen #(.DIV(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .halt(halt),
    .cpu_clk(a_cpu), .clk_d(a_cd), .clk_e(a_ce), .clk_s(a_cs), .step_rst(a_sr),
    .busy(a_busy), .cycle_done(a_done), .cycle_cnt(a_cnt)
  );

  clock_phase_gen #(.DIV(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .halt(halt),
    .cpu_clk(b_cpu), .clk_d(b_cd), .clk_e(b_ce), .clk_s(b_cs), .step_rst(b_sr),
    .busy(b_busy), .cycle_done(b_done), .cycle_cnt(b_cnt)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = MHold;
    m.hold = 0;
    m.pos  = 0;
    m.cnt  = 0;
    m.done = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int div, logic r, logic s, logic h);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    case (m.mode)
      MHold: begin
        n.hold = m.hold + 1;
        if (n.hold == 4) n.mode = MIdle;
      end
      MIdle: begin
        if (!h && (r || s)) begin
          n.mode = r ? MRun : MSingle;
          n.pos  = 0;
        end
      end
      default: begin
        if (m.pos == 4 * div - 1) begin
          n.done = 1'b1;
          n.cnt  = m.cnt + 1;
          if (m.mode == MRun && r && !h) n.pos = 0;
          else n.mode = MIdle;
        end else begin
          n.pos = m.pos + 1;
        end
      end
    endcase
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(string tag, int div, int cntw, mdl_t m, logic cpu, logic cd,
                           logic ce, logic cs, logic sr, logic bz, logic dn, logic [15:0] cnt);
    bit act, ecpu, ecd;
    int qt;
    act  = (m.mode == MRun) || (m.mode == MSingle);
    qt   = m.pos / div;
    ecpu = act && (qt < 2);
    ecd  = act && (qt == 1 || qt == 2);
    chk({tag, ".cpu_clk"}, 32'(cpu), 32'(ecpu));
    chk({tag, ".clk_d"}, 32'(cd), 32'(ecd));
    chk({tag, ".clk_e"}, 32'(ce), 32'(ecpu | ecd));
    chk({tag, ".clk_s"}, 32'(cs), 32'(ecpu & ecd));
    chk({tag, ".step_rst"}, 32'(sr), 32'(m.mode == MHold));
    chk({tag, ".busy"}, 32'(bz), 32'(act));
    chk({tag, ".cycle_done"}, 32'(dn), 32'(m.done));
    chk({tag, ".cycle_cnt"}, 32'(cnt), 32'(m.cnt % (1 << cntw)));
  endtask

  task automatic check_all();
    check_dut("a", 2, 16, ma, a_cpu, a_cd, a_ce, a_cs, a_sr, a_busy, a_done, a_cnt);
    check_dut("b", 1, 4, mb, b_cpu, b_cd, b_ce, b_cs, b_sr, b_busy, b_done, {12'd0, b_cnt});
  endtask

  // One clk: models advance on the rising edge, outputs are checked on the falling edge
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) begin
        ma = mdl_step(ma, 2, run, step_req, halt);
        mb = mdl_step(mb, 1, run, step_req, halt);
      end
      @(negedge clk);
      check_all();
    end
  endtask

  // Asynchronous reset taken between edges; outputs must react without a clk edge
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    step_req = 1'b0;
    halt = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();

    // Reset and release: step_rst falls on the 4th edge
    tick(3);
    rst_n = 1'b1;
    tick(8);

    // Free run
    run = 1'b1;
    tick(26);
    run = 1'b0;
    tick(10);

    // Single step, with a second request landing in q2 of the DIV=2 instance
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(4);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(12);

    // Halt asserted during q1 lets the cycle finish
    run = 1'b1;
    tick(3);
    halt = 1'b1;
    tick(10);
    // Halt blocks starts even with run high
    tick(5);
    // run and step_req together: run wins
    halt = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(20);

    // Reset dropped mid-cycle, in q1 of the DIV=2 instance
    run = 1'b0;
    tick(10);
    run = 1'b1;
    tick(3);
    async_reset();
    tick(2);
    rst_n = 1'b1;
    tick(5);

    // Long free run: the CNT_W=4 instance wraps 15 -> 0 -> 1
    tick(75);
    run = 1'b0;
    tick(10);

    // Randomized control traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      halt = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
